// File: rtl/mux_arb_n.sv
// N-input registered selector with valid/ready handshakes. It picks a channel by
// explicit select (mode 0) or by round-robin arbitration (mode 1) into a one-entry output register.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;
  int               cand;

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_vld;

  // NOTE: every signal written in always_comb is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (!mode) begin
      // Comparing against each legal index keeps sel >= N from reading outside in_valid.
      for (int k = 0; k < N; k++) begin
        if (int'(sel) == k && in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(k);
        end
      end
    end else begin
      // Walk from the farthest candidate to the nearest so the nearest one after rr_ptr wins.
      for (int i = N; i >= 1; i--) begin
        cand = int'(rr_ptr) + i;
        if (cand >= N) cand = cand - N;
        if (in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(cand);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SELW'(k)) grant_data = in_data[k*WIDTH +: WIDTH];
      in_ready[k] = xfer && !reset && (grant_idx == SELW'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant_idx;
      rr_ptr    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a vector table for select/arbitration plus
// hand sequences for backpressure, asynchronous reset and a non-power-of-two N.
module tb_mux_arb_n;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic              clk;
  logic              reset;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   out_src;

  logic              mode3;
  logic [1:0]        sel3;
  logic [3*WIDTH-1:0] in_data3;
  logic [2:0]        in_valid3;
  logic [2:0]        in_ready3;
  logic [WIDTH-1:0]  out_data3;
  logic              out_valid3;
  logic              out_ready3;
  logic [1:0]        out_src3;

  int n_cmp  = 0;
  int n_fail = 0;

  mux_arb_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src)
  );

  mux_arb_n #(.WIDTH(WIDTH), .N(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_src(out_src3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                              input logic ordy, input logic [3:0] rdy, input logic vld,
                              input logic [1:0] src, input logic [31:0] data);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_vld = vld; v.exp_src = src; v.exp_data = data;
    return v;
  endfunction

  initial begin
    // Table starts with output holding DEADBEEF from ch2 and rr_ptr = 2.
    vt[0]  = mk(0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 32'hDEADBEEF);
    vt[1]  = mk(0, 2'd1, 4'b1101, 1, 4'b0000, 0, 2'd2, 32'hDEADBEEF);
    vt[2]  = mk(0, 2'd3, 4'b1101, 1, 4'b1000, 1, 2'd3, 32'h44444444);
    vt[3]  = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 32'h11111111);
    vt[4]  = mk(1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 32'h22222222);
    vt[5]  = mk(1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'h33333333);
    vt[6]  = mk(1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 32'h44444444);
    vt[7]  = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 2'd0, 32'h11111111);
    vt[8]  = mk(1, 2'd0, 4'b1111, 1, 4'b0010, 1, 2'd1, 32'h22222222);
    vt[9]  = mk(1, 2'd0, 4'b1111, 1, 4'b0100, 1, 2'd2, 32'h33333333);
    vt[10] = mk(1, 2'd0, 4'b1111, 1, 4'b1000, 1, 2'd3, 32'h44444444);
    vt[11] = mk(1, 2'd0, 4'b1001, 1, 4'b0001, 1, 2'd0, 32'h11111111);
    vt[12] = mk(1, 2'd0, 4'b1001, 1, 4'b1000, 1, 2'd3, 32'h44444444);
    vt[13] = mk(1, 2'd0, 4'b1001, 1, 4'b0001, 1, 2'd0, 32'h11111111);
    vt[14] = mk(1, 2'd0, 4'b0000, 0, 4'b0000, 1, 2'd0, 32'h11111111);
    vt[15] = mk(0, 2'd2, 4'b0100, 0, 4'b0000, 1, 2'd0, 32'h11111111);
    vt[16] = mk(0, 2'd2, 4'b0100, 1, 4'b0100, 1, 2'd2, 32'h33333333);
    vt[17] = mk(1, 2'd0, 4'b0110, 1, 4'b0010, 1, 2'd1, 32'h22222222);
    vt[18] = mk(1, 2'd0, 4'b0110, 1, 4'b0100, 1, 2'd2, 32'h33333333);
    vt[19] = mk(1, 2'd0, 4'b0000, 1, 4'b0000, 0, 2'd2, 32'h33333333);

    reset = 1'b1;
    mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1; in_data = '0;
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1; in_data3 = '0;

    // Reset state, with requests present: in_ready must stay low while reset is high.
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_src", out_src, 0);
    check("rst in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First transfer: explicit select of ch2.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
    in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    check("first in_ready", in_ready, 4'b0100);
    tick();
    check("first out_valid", out_valid, 1);
    check("first out_data", out_data, 32'hDEADBEEF);
    check("first out_src", out_src, 2);

    for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 32'h11111111 * (k + 1);

    for (int i = 0; i < NV; i++) begin
      mode = vt[i].mode; sel = vt[i].sel; in_valid = vt[i].iv; out_ready = vt[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), in_ready, vt[i].exp_rdy);
      tick();
      check($sformatf("v%0d out_valid", i), out_valid, vt[i].exp_vld);
      check($sformatf("v%0d out_src", i), out_src, vt[i].exp_src);
      check($sformatf("v%0d out_data", i), out_data, vt[i].exp_data);
    end

    // Backpressure: a held word must ignore changing inputs for three cycles.
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    in_data[1*WIDTH +: WIDTH] = 32'hCAFE0001;
    tick();
    check("bp load out_src", out_src, 1);
    check("bp load out_data", out_data, 32'hCAFE0001);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 32'hBAD00000 + 32'(j * 16 + k);
      #1;
      check($sformatf("bp%0d in_ready", j), in_ready, 0);
      tick();
      check($sformatf("bp%0d out_valid", j), out_valid, 1);
      check($sformatf("bp%0d out_src", j), out_src, 1);
      check($sformatf("bp%0d out_data", j), out_data, 32'hCAFE0001);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 4'b0100);
    tick();
    check("bp release out_valid", out_valid, 1);
    check("bp release out_src", out_src, 2);
    check("bp release out_data", out_data, 32'hBAD00022);

    // Asynchronous reset mid-stream, away from any clock edge.
    reset = 1'b1;
    #1;
    check("arst out_valid", out_valid, 0);
    check("arst out_data", out_data, 0);
    check("arst out_src", out_src, 0);
    check("arst in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 4'b0001);
    tick();
    check("post-rst out_src", out_src, 0);
    check("post-rst out_data", out_data, 32'hBAD00020);

    // N = 3: sel = 3 is out of range and must grant nothing.
    for (int k = 0; k < 3; k++) in_data3[k*WIDTH +: WIDTH] = 32'h70000000 + 32'(k);
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    check("n3 sel3 in_ready", in_ready3, 0);
    tick();
    check("n3 sel3 out_valid", out_valid3, 0);
    check("n3 sel3 out_data", out_data3, 0);
    sel3 = 2'd2;
    #1;
    check("n3 sel2 in_ready", in_ready3, 3'b100);
    tick();
    check("n3 sel2 out_src", out_src3, 2);
    check("n3 sel2 out_data", out_data3, 32'h70000002);
    // Round-robin wrap with N = 3: after ch2 the next grant is ch0.
    mode3 = 1'b1;
    #1;
    check("n3 rr wrap in_ready", in_ready3, 3'b001);
    tick();
    check("n3 rr wrap out_src", out_src3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes. It is the next generation of the datapath 4:1 select muxes. Mode 0 selects the channel given by an explicit select (control-unit driven). Mode 1 arbitrates round-robin among requesting channels, for shared resources such as the memory port (fetch vs. load/store). Output is a one-entry register, so selection adds exactly one pipeline stage.

Parameters:
WIDTH, 32, data width of each channel
N, 4, number of input channels (2..16)
SELW, 2, select/index width; must equal ceil(log2(N)), minimum 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration
sel  input  SELW  channel index used when mode = 0
in_data  input  N*WIDTH  flattened channel data; channel k at bits [k*WIDTH +: WIDTH]
in_valid  input  N  per-channel request/valid
in_ready  output  N  per-channel accept; at most one bit high
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data this cycle
out_src  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset (async, any time): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1 (channel 0 has first priority). in_ready is combinational and reads 0 while reset is high. A word in flight is dropped.
- load_en = !out_valid | out_ready. The output register can take a new word when empty or being drained in the same cycle.
- Grant (combinational):
  - mode=0: grant=sel if sel<N and in_valid[sel]. sel>=N means no grant, and no X or out-of-range read.
  - mode=1: first k with in_valid[k], searched in order rr_ptr+1, rr_ptr+2, ... modulo N (wrap-around).
  - No valid candidate: no grant.
- in_ready[k]=1 only when load_en and k is the grant. A transfer on channel k happens when in_valid[k] & in_ready[k].
- On transfer at edge: out_data<=channel k data, out_src<=k, out_valid<=1, rr_ptr<=k. rr_ptr updates in both modes.
- On out_valid & out_ready with no new transfer: out_valid<=0. out_data and out_src hold their last values.
- Simultaneous drain and transfer: out_valid stays 1 and the new word replaces the old one. Full throughput is one word per cycle.
- Backpressure (out_valid & !out_ready):
  - All in_ready=0.
  - out_data, out_src and out_valid are held stable.
  - Input changes have no effect.
- Latency: input accepted at edge t appears on out_data after edge t, i.e. one cycle.
- Mode or sel may change any cycle. The change affects only the next grant decision; a held output word is unaffected; rr_ptr is preserved across mode changes.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0. No channel waits more than N-1 transfers.
- No combinational path from out_ready to out_data. The out_ready to in_ready path is permitted and combinational.

Test Plan:
- Reset then mode=0, sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2.
- mode=0, sel=1, in_valid=4'b1101 -> in_ready=0, out_valid stays 0. Also with N=3 and sel=3: no grant, no X on outputs.
- mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, back-to-back out_valid=1.
- mode=1, in_valid=4'b1001 after a grant to ch3 -> next grant ch0 (wrap-around), then ch3.
- Word on output, out_ready=0 for 3 cycles while ch data changes -> out_data/out_src constant, in_ready=0. Then out_ready=1 -> old word consumed and new word loaded in the same edge.
- Assert reset mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately (asynchronous). After release, mode=1 with in_valid=4'b1111 grants ch0 first.
